// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// The DIV/DIVU decode depends on MULDIV_DIV_EN.
package muldiv_pkg;

  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;
  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_div_funct(input logic [5:0] f);
    return (f == DIV) || (f == DIVU);
  endfunction

  // Iterative ops this build actually executes.
  function automatic logic is_muldiv_funct(input logic [5:0] f);
`ifdef MULDIV_DIV_EN
    return (f == MULT) || (f == MULTU) || is_div_funct(f);
`else
    return (f == MULT) || (f == MULTU);
`endif
  endfunction

  function automatic logic is_hilo_funct(input logic [5:0] f);
    return is_muldiv_funct(f) || (f == MFHI) || (f == MTHI) ||
           (f == MFLO) || (f == MTLO);
  endfunction

  function automatic logic is_signed_funct(input logic [5:0] f);
    return (f == MULT) || (f == DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration of the mul/div datapath.
// Multiply: shift-add of operand into the upper half, right shift.
// Divide (only with MULDIV_DIV_EN): restoring shift-subtract,
// accumulator holds {remainder, dividend/quotient}.
module muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_diff;
  logic              sub_ok;
  logic [2*XLEN-1:0] div_next;

  // Shifted remainder is XLEN+1 bits wide; when the subtract succeeds the
  // true difference fits in XLEN bits, so the low bits are exact.
  always_comb begin
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    sub_ok   = rem_sh >= {1'b0, operand};
    rem_diff = rem_sh[XLEN-1:0] - operand;
    div_next = sub_ok ? {rem_diff, acc[XLEN-2:0], 1'b1}
                      : {acc[2*XLEN-2:0], 1'b0};
    acc_next = is_div ? div_next : mul_next;
  end
`else
  always_comb begin
    acc_next = is_div ? acc : mul_next;
  end
`endif

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit with HI/LO and MF/MT handling.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU are ignored.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] mf_result,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_next, prod;
  logic [XLEN-1:0]   opnd_q, hi_q, lo_q;
  logic [XLEN-1:0]   mag_a, mag_b, fix_hi, fix_lo;
  logic              neg_q, done_q, accept_md, op_signed, iter_div;

`ifdef MULDIV_DIV_EN
  logic              is_div_q, neg_rem_q, div0_q, op_div;
  logic [XLEN-1:0]   dvd_raw_q;
  assign op_div   = is_div_funct(funct);
  assign iter_div = is_div_q;
`else
  assign iter_div = 1'b0;
`endif

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .is_div   (iter_div),
    .acc      (acc_q),
    .operand  (opnd_q),
    .acc_next (acc_next)
  );

  always_comb begin
    accept_md = (state_q == IDLE) && op_valid && is_muldiv_funct(funct);
    op_signed = is_signed_funct(funct);
    mag_a     = (op_signed && rs_val[XLEN-1]) ? -rs_val : rs_val;
    mag_b     = (op_signed && rt_val[XLEN-1]) ? -rt_val : rt_val;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_md) state_d = CALC;
      CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod   = neg_q ? -acc_q : acc_q;
    fix_hi = prod[2*XLEN-1:XLEN];
    fix_lo = prod[XLEN-1:0];
`ifdef MULDIV_DIV_EN
    if (is_div_q) begin
      if (div0_q) begin
        fix_lo = '1;
        fix_hi = dvd_raw_q;
      end else begin
        fix_lo = neg_q     ? -acc_q[XLEN-1:0]      : acc_q[XLEN-1:0];
        fix_hi = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      dvd_raw_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept_md) begin
            cnt_q  <= '0;
            neg_q  <= op_signed && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
            acc_q  <= {{XLEN{1'b0}}, mag_b};
            opnd_q <= mag_a;
`ifdef MULDIV_DIV_EN
            is_div_q  <= op_div;
            neg_rem_q <= op_signed && rs_val[XLEN-1];
            div0_q    <= (rt_val == '0);
            dvd_raw_q <= rs_val;
            if (op_div) begin
              acc_q  <= {{XLEN{1'b0}}, mag_a};
              opnd_q <= mag_b;
            end
`endif
          end else if (op_valid && funct == MTHI) begin
            hi_q <= rs_val;
          end else if (op_valid && funct == MTLO) begin
            lo_q <= rs_val;
          end
        end
        CALC: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mf_result = '0;
    if (state_q == IDLE && op_valid) begin
      if (funct == MFHI) mf_result = hi_q;
      else if (funct == MFLO) mf_result = lo_q;
    end
  end

  assign busy   = (state_q != IDLE);
  assign stall  = busy && op_valid && is_hilo_funct(funct);
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit; DIV expectations follow MULDIV_DIV_EN.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [5:0]  funct = 6'h20;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        stall, busy, done;
  logic [31:0] mf_result, hi_out, lo_out;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .funct     (funct),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .mf_result (mf_result),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  always #5 clk = ~clk;

  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] acc_cyc;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    done_seen = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string t;
    if (reset && done) begin
      done_seen++;
      if (sb.size() == 0) begin
        check_eq("spurious_done", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        t = sb_tag.pop_front();
        check_eq({t, "_hi"}, 64'(hi_out), 64'(e.hi));
        check_eq({t, "_lo"}, 64'(lo_out), 64'(e.lo));
        check_eq({t, "_lat"}, 64'(cyc - e.acc_cyc), 64'd33);
        check_eq({t, "_busy"}, 64'(busy), 64'd0);
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; funct = f; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    op_valid = 1'b0; funct = 6'h20;
  endtask

  task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    drive(f, a, b);
    e.hi = ehi; e.lo = elo; e.acc_cyc = cyc;
    sb.push_back(e);
    sb_tag.push_back(tag);
    m_hi = ehi; m_lo = elo;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 80; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check_eq({tag, "_drain"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic run_ignored(input string tag, input logic [5:0] f, input logic [31:0] a,
                             input logic [31:0] b);
    drive(f, a, b);
    @(negedge clk);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check_eq({tag, "_hi"}, 64'(hi_out), 64'(m_hi));
    check_eq({tag, "_lo"}, 64'(lo_out), 64'(m_lo));
  endtask

  // Holds the current op_valid/funct until stall drops; returns stalled cycles.
  task automatic count_stall(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
      @(posedge clk);
    end
  endtask

  initial begin
    int n;
    int seen;

    // Reset state, with an MFLO presented to exercise stall/mf_result.
    reset = 1'b0; op_valid = 1'b1; funct = MFLO;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_hi", 64'(hi_out), 64'd0);
    check_eq("rst_lo", 64'(lo_out), 64'd0);
    check_eq("rst_mf", 64'(mf_result), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1; op_valid = 1'b0; funct = 6'h20;
    @(posedge clk); #1;

    run_md("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk);
    check_eq("multu_max_busy_e0", 64'(busy), 64'd1);
    wait_drain("multu_max");

    run_md("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    wait_drain("mult_neg");

`ifdef MULDIV_DIV_EN
    run_md("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_drain("div_neg");
    run_md("div_negdvs", DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    wait_drain("div_negdvs");
    run_md("divu_plain", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_drain("divu_plain");
    run_md("divu_zero", DIVU, 32'd10, 32'd0, 32'h0000_000A, 32'hFFFF_FFFF);
    wait_drain("divu_zero");
    run_md("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    wait_drain("div_ovf");
`else
    run_ignored("div_off", DIV, 32'hFFFF_FFF9, 32'd2);
    run_ignored("divu_off", DIVU, 32'd10, 32'd0);
`endif

    // MULT, ADD, MFLO back to back.
    run_md("mult_pipe", MULT, 32'd5, 32'd6, 32'd0, 32'd30);
    op_valid = 1'b1; funct = 6'h20;
    @(negedge clk);
    check_eq("add_stall", 64'(stall), 64'd0);
    check_eq("add_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    funct = MFLO;
    count_stall(n);
    check_eq("mflo_stall_cycles", 64'(n), 64'd32);
    check_eq("mflo_result", 64'(mf_result), 64'd30);
    @(posedge clk); #1;
    op_valid = 1'b0; funct = 6'h20;
    wait_drain("mult_pipe");

    // MFHI directly behind MULTU.
    run_md("multu_dep", MULTU, 32'h0001_0000, 32'h0003_0000, 32'd3, 32'd0);
    op_valid = 1'b1; funct = MFHI;
    count_stall(n);
    check_eq("mfhi_stall_cycles", 64'(n), 64'd33);
    check_eq("mfhi_result", 64'(mf_result), 64'd3);
    @(posedge clk); #1;
    op_valid = 1'b0; funct = 6'h20;
    wait_drain("multu_dep");

    // MT then MF.
    drive(MTHI, 32'h0000_1234, 32'd0);
    op_valid = 1'b1; funct = MFHI;
    @(negedge clk);
    check_eq("mthi_mf", 64'(mf_result), 64'h1234);
    @(posedge clk); #1;
    op_valid = 1'b0;
    drive(MTLO, 32'h0000_CAFE, 32'd0);
    op_valid = 1'b1; funct = MFLO;
    @(negedge clk);
    check_eq("mtlo_mf", 64'(mf_result), 64'hCAFE);
    @(posedge clk); #1;
    op_valid = 1'b0; funct = 6'h20;

    // MTLO held behind a busy MULTU, accepted right after return to IDLE.
    run_md("multu_mt", MULTU, 32'd3, 32'd4, 32'd0, 32'd12);
    op_valid = 1'b1; funct = MTLO; rs_val = 32'h55;
    count_stall(n);
    check_eq("mt_stall_cycles", 64'(n), 64'd33);
    @(posedge clk); #1;
    op_valid = 1'b0; funct = 6'h20;
    @(negedge clk);
    check_eq("mt_late_lo", 64'(lo_out), 64'h55);
    check_eq("mt_late_hi", 64'(hi_out), 64'd0);
    @(posedge clk); #1;
    wait_drain("multu_mt");

    // Abort at cnt = 15.
    drive(MULTU, 32'h0000_FFFF, 32'h0000_FFFF);
    repeat (15) @(posedge clk);
    #1; reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_hi", 64'(hi_out), 64'd0);
    check_eq("abort_lo", 64'(lo_out), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    seen = done_seen;
    repeat (40) @(posedge clk);
    #1;
    check_eq("abort_no_done", 64'(done_seen - seen), 64'd0);

    run_md("multu_after_rst", MULTU, 32'd2, 32'd3, 32'd0, 32'd6);
    wait_drain("multu_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit for the EX stage, consuming the operands and funct field delivered by the ID/EX pipeline register. It executes MULT/MULTU/DIV/DIVU over multiple cycles into architectural HI/LO registers, services MFHI/MFLO/MTHI/MTLO, and raises a stall toward the hazard logic while a HI/LO-dependent instruction must wait. Its results feed the EX/MEM register through the EX result mux.

## Interface
Parameters:
- `XLEN`, 32: operand and HI/LO width. Only 32 is supported.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — synchronous, active-low reset, sampled on the rising edge of `clk`.
- `op_valid`  in  1  — the ID/EX entry is an R-type instruction with a live funct field.
- `funct`  in  6  — funct field from ID/EX.
- `rs_val`  in  32  — first operand (RD1) from ID/EX.
- `rt_val`  in  32  — second operand (RD2) from ID/EX.
- `stall`  out  1  — hold the PC, IF/ID and ID/EX, and insert a bubble into EX/MEM.
- `busy`  out  1  — an iterative operation is in flight.
- `done`  out  1  — one-cycle pulse after HI/LO take a mul/div result.
- `mf_result`  out  32  — HI for MFHI, LO for MFLO, otherwise 0.
- `hi_out`  out  32  — architectural HI.
- `lo_out`  out  32  — architectural LO.

## Operation
- Funct decode:
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU.
  - 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO.
  - Every other funct is ignored.
- FSM states:
  - IDLE → CALC: on an accepted mul/div. Latch the operand magnitudes (absolute values for signed ops), record the result signs, clear `cnt`.
  - CALC: one iteration per cycle, `cnt` 0..31.
    - Multiply: shift-add into a 64-bit accumulator.
    - Divide: restoring shift-subtract, giving a 32-bit quotient and remainder.
  - CALC → FIX: when `cnt`==31.
  - FIX: apply signs, write HI/LO, then → IDLE.
- Signed result rules:
  - Product negated when the operand signs differ.
  - Quotient negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Result placement:
  - MULT/MULTU: HI = product[63:32], LO = product[31:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU): LO = 0xFFFFFFFF, HI = `rs_val` as issued. The operation still takes the full latency.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MTHI/MTLO: write `rs_val` to HI/LO at the next edge, only in IDLE.
- MFHI/MFLO: `mf_result` is combinational from HI/LO, only in IDLE.
- `stall` = `busy` & `op_valid` & (funct is any of the eight HI/LO functs). Instructions that do not touch HI/LO proceed while the unit is busy.
- While busy, a new mul/div or MT is not accepted. It is held by `stall` and accepted on the cycle after return to IDLE.
- Reset values:
  - State IDLE, `cnt` = 0.
  - HI = 0, LO = 0.
  - `busy` = 0, `done` = 0, `stall` = 0 (combinational from `busy`).
  - `mf_result` = 0.
- Reset mid-operation aborts the computation. HI/LO are cleared; no `done` is produced.

## Timing
- Accept edge E0: `busy` = 1 from E0.
- CALC iterations occur on edges E1..E32.
- The FIX write happens at E33. HI/LO are valid and `done` = 1 in the cycle after E33, and `busy` = 0 in that same cycle.
- Mul/div latency is 33 cycles from accept to a visible result.
- A dependent MFHI/MFLO stalls 33 cycles after E0 and reads the new value in the first cycle after E33.
- MT latency: 1 cycle. A following MF, one cycle later, sees the new value.
- `done` is a registered pulse, exactly one cycle long.

## Configuration
- `MULDIV_DIV_EN` defined:
  - Divider datapath and the divide special cases are compiled in.
- `MULDIV_DIV_EN` undefined:
  - DIV/DIVU are treated as ignored functs: no `busy`, no `stall`, no `done`, HI/LO unchanged.
  - MULT/MULTU and MF/MT are unaffected.

## Structure
- Shared package `muldiv_pkg`: funct constants (MULT, MULTU, DIV, DIVU, MFHI, MTHI, MFLO, MTLO) and the FSM state encoding (IDLE, CALC, FIX).
- Sub-module `muldiv_iter`: one-iteration combinational step. It takes the mode (mul/div), accumulator, and operand, and returns the next accumulator. The top level owns the FSM, the counter, sign handling and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. `done` appears 33 cycles after accept.
- MULT −3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 10 / 0 → LO = 0xFFFFFFFF, HI = 0x0000000A. DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- MULT, then an ADD, then MFLO in consecutive cycles:
  - ADD is not stalled.
  - MFLO has `stall` = 1 until the FIX write, then `mf_result` = the new LO.
  - MTHI 0x1234 followed by MFHI → 0x1234.
- `reset` = 0 during CALC at cnt = 15 → the cycle after the reset edge shows `busy` = 0, HI = LO = 0, and no `done` pulse.
  - A fresh MULTU 2 × 3 then gives LO = 6.
